if_id_stage: RTL and testbench

IF_ID_STAGE -- requirements
Module: if_id_stage

---
 rtl/if_id_stage.sv | 148 ++++++++++++++
 tb/tb_if_id_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - instruction fetch / IF-ID pipeline register with stall, redirect and halt
//
// Purpose: holds the fetch PC and the IF/ID register. After reset, one FILL
// cycle primes ID. The stage then runs with per-cycle priority
// halt > stall > redirect > sequential, and finally freezes in HALT.
// Optional feature macro: IF_STALL_COUNT_EN adds a saturating stall_count output.
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   nop_lock_id      stall request from the data-dependence unit
//   Jump_id[1:0]     jump class in ID (00 none, 01 jr, 10 j, 11 jal)
//   branch_taken_id  conditional branch in ID resolved taken
//   target_id[31:0]  redirect address; bits [1:0] ignored
//   halt_id          syscall-exit decoded in ID
//   instr_if[31:0]   ROM data for pc_if (combinational)
//   pc_if[31:0]      fetch address to the ROM
//   pc_id, instr_id, valid_id  IF/ID register contents
//   halted           sticky halt flag
//   fetch_count      instructions latched into ID with valid_id=1
//   stall_count      (IF_STALL_COUNT_EN only) RUN cycles stalled on a valid ID
module if_id_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        nop_lock_id,
  input  logic [1:0]  Jump_id,
  input  logic        branch_taken_id,
  input  logic [31:0] target_id,
  input  logic        halt_id,
  input  logic [31:0] instr_if,
  output logic [31:0] pc_if,
  output logic [31:0] pc_id,
  output logic [31:0] instr_id,
  output logic        valid_id,
  output logic        halted,
  output logic [31:0] fetch_count
`ifdef IF_STALL_COUNT_EN
  ,
  output logic [31:0] stall_count
`endif
);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  // Fetch addresses are word aligned; drop any low bits of the reset vector.
  localparam logic [31:0] PC_RESET_AL = {PC_RESET[31:2], 2'b00};

  state_t      state_q, state_d;
  logic [31:0] pc_if_d, pc_id_d, instr_id_d, fetch_count_d;
  logic        valid_id_d, halted_d;
  logic        do_halt, do_stall, do_redirect, do_fetch;
  logic        unused_target_lsb;

  assign unused_target_lsb = ^target_id[1:0];

  always_comb begin
    state_d       = state_q;
    pc_if_d       = pc_if;
    pc_id_d       = pc_id;
    instr_id_d    = instr_id;
    valid_id_d    = valid_id;
    halted_d      = halted;
    fetch_count_d = fetch_count;
    do_halt       = 1'b0;
    do_stall      = 1'b0;
    do_redirect   = 1'b0;
    do_fetch      = 1'b0;

    case (state_q)
      FILL: begin
        do_fetch = 1'b1;
        state_d  = RUN;
      end
      RUN: begin
        // A bubble in ID carries no instruction, so its control inputs are
        // meaningless and every qualifier below is gated by valid_id.
        do_halt     = halt_id & valid_id;
        do_stall    = ~do_halt & nop_lock_id & valid_id;
        do_redirect = ~do_halt & ~do_stall & valid_id &
                      ((Jump_id != 2'b00) | branch_taken_id);
        do_fetch    = ~do_halt & ~do_stall & ~do_redirect;
        if (do_halt) state_d = HALT;
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = FILL;
      end
    endcase

    if (do_fetch) begin
      pc_if_d       = pc_if + 32'd4;
      pc_id_d       = pc_if;
      instr_id_d    = instr_if;
      valid_id_d    = 1'b1;
      fetch_count_d = fetch_count + 32'd1;
    end else if (do_redirect) begin
      // No delay slot: the instruction fetched behind the jump is squashed.
      pc_if_d    = {target_id[31:2], 2'b00};
      instr_id_d = 32'd0;
      valid_id_d = 1'b0;
    end else if (do_halt) begin
      instr_id_d = 32'd0;
      valid_id_d = 1'b0;
      halted_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      pc_if       <= PC_RESET_AL;
      pc_id       <= 32'd0;
      instr_id    <= 32'd0;
      valid_id    <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_if       <= pc_if_d;
      pc_id       <= pc_id_d;
      instr_id    <= instr_id_d;
      valid_id    <= valid_id_d;
      halted      <= halted_d;
      fetch_count <= fetch_count_d;
    end
  end

`ifdef IF_STALL_COUNT_EN
  // Counts every RUN cycle that presents a stall request on a valid ID
  // instruction, even when a concurrent halt takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= 32'd0;
    end else if ((state_q == RUN) && nop_lock_id && valid_id &&
                 (stall_count != 32'hFFFF_FFFF)) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - self-checking bench for if_id_stage
module tb_if_id_stage;

  logic        clk;
  logic        rst_n;
  logic        nop_lock_id;
  logic [1:0]  Jump_id;
  logic        branch_taken_id;
  logic [31:0] target_id;
  logic        halt_id;
  logic [31:0] instr_if;
  logic [31:0] pc_if;
  logic [31:0] pc_id;
  logic [31:0] instr_id;
  logic        valid_id;
  logic        halted;
  logic [31:0] fetch_count;
`ifdef IF_STALL_COUNT_EN
  logic [31:0] stall_count;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [31:0] m_pc_if, m_pc_id, m_instr, m_fc, m_sc;
  bit          m_valid, m_halted, m_started;

  if_id_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .nop_lock_id     (nop_lock_id),
    .Jump_id         (Jump_id),
    .branch_taken_id (branch_taken_id),
    .target_id       (target_id),
    .halt_id         (halt_id),
    .instr_if        (instr_if),
    .pc_if           (pc_if),
    .pc_id           (pc_id),
    .instr_id        (instr_id),
    .valid_id        (valid_id),
    .halted          (halted),
    .fetch_count     (fetch_count)
`ifdef IF_STALL_COUNT_EN
    ,
    .stall_count     (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign instr_if = rom(pc_if);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc_if"}, pc_if, m_pc_if);
    check({tag, ".valid_id"}, {31'd0, valid_id}, {31'd0, m_valid});
    check({tag, ".instr_id"}, instr_id, m_instr);
    if (m_valid) check({tag, ".pc_id"}, pc_id, m_pc_id);
    check({tag, ".halted"}, {31'd0, halted}, {31'd0, m_halted});
    check({tag, ".fetch_count"}, fetch_count, m_fc);
`ifdef IF_STALL_COUNT_EN
    check({tag, ".stall_count"}, stall_count, m_sc);
`endif
  endtask

  task automatic model_reset();
    m_pc_if = 32'h0000_3000; m_pc_id = 0; m_instr = 0; m_fc = 0; m_sc = 0;
    m_valid = 0; m_halted = 0; m_started = 0;
  endtask

  task automatic model_fetch();
    m_pc_id = m_pc_if;
    m_instr = rom(m_pc_if);
    m_valid = 1;
    m_pc_if = m_pc_if + 32'd4;
    m_fc    = m_fc + 32'd1;
  endtask

  // One clock edge of the stage, derived from the behavioural rules.
  task automatic model_edge();
    if (m_halted) return;
    if (!m_started) begin
      m_started = 1;
      model_fetch();
      return;
    end
    if (m_valid && nop_lock_id && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
    if (m_valid && halt_id) begin
      m_halted = 1; m_valid = 0; m_instr = 0;
    end else if (m_valid && nop_lock_id) begin
      // held
    end else if (m_valid && (Jump_id != 2'b00 || branch_taken_id)) begin
      m_pc_if = target_id & 32'hFFFF_FFFC;
      m_instr = 0;
      m_valid = 0;
    end else begin
      model_fetch();
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    nop_lock_id = 0; Jump_id = 2'b00; branch_taken_id = 0; target_id = 0; halt_id = 0;
  endtask

  task automatic ensure_valid();
    idle_inputs();
    for (int i = 0; i < 3 && !m_valid; i++) step("settle");
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #12;
    check_all("reset");

    #10 rst_n = 1'b1;   // released mid-cycle

    // Free-running fetch from PC_RESET
    step("free1");
    check("free1.pc_id_lit", pc_id, 32'h0000_3000);
    step("free2");
    step("free3");
    check("free3.pc_if_lit", pc_if, 32'h0000_300C);
    check("free3.pc_id_lit", pc_id, 32'h0000_3008);

    // Two-cycle stall holding pc_id = 0x3008
    nop_lock_id = 1;
    step("stall1");
    step("stall2");
    check("stall2.pc_id_lit", pc_id, 32'h0000_3008);

    // jr concurrent with stall: stall wins, redirect follows once released
    Jump_id = 2'b01; target_id = 32'h0000_3200;
    step("jr_stalled");
    nop_lock_id = 0;
    step("jr_release");
    check("jr_release.pc_if_lit", pc_if, 32'h0000_3200);
    step("jr_bubble");   // Jump_id still up but ID is a bubble: ignored
    idle_inputs();
    step("post_jr");

    // Jump to 0x3100, no delay slot
    Jump_id = 2'b10; target_id = 32'h0000_3100;
    step("j_edge");
    check("j_edge.pc_if_lit", pc_if, 32'h0000_3100);
    idle_inputs();
    step("j_follow");
    check("j_follow.pc_id_lit", pc_id, 32'h0000_3100);

    // Randomized run without halt
    for (int i = 0; i < 200; i++) begin
      nop_lock_id     = ($urandom_range(0, 3) == 0);
      Jump_id         = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      branch_taken_id = ($urandom_range(0, 7) == 0);
      target_id       = $urandom;
      halt_id         = 0;
      step("rand");
    end

    // Address wrap at the top of memory (low target bits must be dropped)
    ensure_valid();
    Jump_id = 2'b11; target_id = 32'hFFFF_FFFF;
    step("wrap_redirect");
    check("wrap_redirect.pc_if_lit", pc_if, 32'hFFFF_FFFC);
    idle_inputs();
    step("wrap_seq");
    check("wrap_seq.pc_if_lit", pc_if, 32'h0000_0000);

    // Halt and hold under random stimulus
    ensure_valid();
    halt_id = 1;
    step("halt_edge");
    for (int i = 0; i < 12; i++) begin
      nop_lock_id     = 1'($urandom);
      Jump_id         = 2'($urandom);
      branch_taken_id = 1'($urandom);
      target_id       = $urandom;
      halt_id         = 1'($urandom);
      step("halted");
    end

    // Asynchronous reset mid-halt, away from any clock edge
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_reset");
    check("async_reset.pc_if_lit", pc_if, 32'h0000_3000);
    #1 rst_n = 1'b1;
    idle_inputs();
    step("refill");
    check("refill.pc_id_lit", pc_id, 32'h0000_3000);
    step("refill2");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
